// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with occupancy level, programmable
//             almost-full/almost-empty thresholds, sticky overflow/underflow
//             flags, synchronous flush and a build-time choice of standard or
//             first-word-fall-through (FWFT) read mode.
//  Ports    : clk          - clock, rising edge
//             rst_n        - asynchronous active-low reset
//             flush        - synchronous clear of contents and error flags
//             wr_en        - write request
//             data_in      - write data
//             rd_en        - read request (standard) / pop (FWFT)
//             data_out     - read data (FWFT: current head word)
//             data_valid   - standard: data_out updated this cycle;
//                            FWFT: head word present (== !empty)
//             full, empty  - occupancy flags
//             almost_full  - level >= AFULL_THRESH
//             almost_empty - level <= AEMPTY_THRESH
//             level        - words held, 0..DEPTH
//             overflow     - sticky: write attempted while full
//             underflow    - sticky: read attempted while empty
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth_lvl = (ADDR_WIDTH + 1)'(c_depth);
  localparam logic [ADDR_WIDTH:0] c_afull     = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] c_aempty    = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [c_depth];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  // Standard mode: one-cycle data_valid pulse. FWFT mode: head register valid.
  logic                  vld_q, vld_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic [ADDR_WIDTH:0]   arr_cnt_w;  // words held in the array only
  logic                  arr_rd_w;   // array word read out this cycle
  logic                  wr_acc_w;

  // Pointers carry an extra wrap bit, so the difference is the array count
  // even when the low bits coincide (full vs empty).
  assign arr_cnt_w = wptr_q - rptr_q;

  generate
    if (FWFT) begin : g_fwft
      logic pop_w;
      assign level    = arr_cnt_w + {{ADDR_WIDTH{1'b0}}, vld_q};
      assign empty    = !vld_q;
      assign pop_w    = rd_en && vld_q;
      // Refill the head register whenever it is free or being popped.
      // The array count is registered, so a word written to an empty FIFO
      // reaches the head register one edge later.
      assign arr_rd_w = (arr_cnt_w != '0) && (!vld_q || pop_w);
      assign vld_d    = arr_rd_w ? 1'b1 : (pop_w ? 1'b0 : vld_q);
    end else begin : g_std
      assign level    = arr_cnt_w;
      assign empty    = (arr_cnt_w == '0);
      assign arr_rd_w = rd_en && !empty;
      assign vld_d    = arr_rd_w;
    end
  endgenerate

  assign full         = (level == c_depth_lvl);
  assign almost_full  = (level >= c_afull);
  assign almost_empty = (level <= c_aempty);
  assign wr_acc_w     = wr_en && !full;

  assign data_out   = dout_q;
  assign data_valid = vld_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

  always_comb begin
    wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc_w};
    rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, arr_rd_w};
    dout_d = arr_rd_w ? mem_q[rptr_q[ADDR_WIDTH-1:0]] : dout_q;
    ovf_d  = ovf_q || (wr_en && full);
    udf_d  = udf_q || (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (flush) begin
      // data_out deliberately keeps its last value across a flush.
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage array has no reset; stale contents are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc_w) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffer: the next generation of the team's FIFO storage. It adds pointer and flag management, occupancy level, programmable almost-full/almost-empty thresholds, overflow/underflow error flags, a synchronous flush, and a build-time choice of standard or first-word-fall-through (FWFT) read mode. It is used wherever producer and consumer share one clock, for example rate smoothing inside one clock domain.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through
- AFULL_THRESH, 56, almost_full asserts when level >= this value
- AEMPTY_THRESH, 8, almost_empty asserts when level <= this value
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of all contents and error flags
- wr_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- rd_en  input  1  read request (standard mode) or pop (FWFT mode)
- data_out  output  DATA_WIDTH  read data
- data_valid  output  1  standard mode: data_out updated this cycle; FWFT mode: equals !empty
- full, empty  output  1  occupancy flags
- almost_full, almost_empty  output  1  threshold flags
- level  output  ADDR_WIDTH+1  words held, 0..DEPTH
- overflow, underflow  output  1  sticky error flags

## Operation
- Storage: DEPTH x DATA_WIDTH array. The write and read pointers are ADDR_WIDTH+1 bits wide; the MSB is the wrap bit, so pointers wrap modulo 2*DEPTH. The array is indexed by the pointer's low ADDR_WIDTH bits.
- level = total words held (array plus FWFT output register). full = (level == DEPTH). empty = (level == 0).
- Write accepted when wr_en && !full. Accepted write: mem[wptr] <= data_in and wptr increments.
- Write with full = 1 is dropped and sets overflow. This holds even when a read is accepted in the same cycle, because full is sampled before the edge.
- Standard mode (FWFT = 0):
  - Read accepted when rd_en && !empty: data_out <= mem[rptr], rptr increments, data_valid = 1 for exactly the next cycle.
  - data_out otherwise holds its last value.
- FWFT mode (FWFT = 1):
  - A one-word output register holds the head word. empty = !out_valid.
  - The output register loads mem[rptr] (and rptr increments) when the array is non-empty and either !out_valid, or rd_en pops the current head.
  - Pop accepted when rd_en && out_valid.
  - After the last pop, data_out holds the stale word and empty = 1.
- Read or pop with empty = 1 is ignored and sets underflow.
- Simultaneous accepted write and read: level is unchanged.
- Simultaneous write and read when empty:
  - The write is accepted; the read sets underflow.
  - In FWFT mode a word written to an empty FIFO lands in the array first, never straight into the output register.
- overflow/underflow are sticky until flush or reset.
- Flush has priority over wr_en/rd_en in the same cycle. It clears pointers, level, out_valid, data_valid, overflow and underflow. data_out is held, not cleared.
- Reset (rst_n = 0, at any time including mid-burst):
  - data_out = 0, data_valid = 0, level = 0, empty = 1, full = 0.
  - almost_empty = 1 (given AEMPTY_THRESH >= 0); almost_full = 0.
  - overflow = 0, underflow = 0.
  - Array contents are not cleared.

## Timing
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- Flags and level reflect the edge at which a request is sampled and are visible in the following cycle.
- Standard mode:
  - A write at edge N deasserts empty after edge N.
  - A read at edge N+1 returns that word after edge N+1.
  - Write-to-data latency is 2 edges.
- FWFT mode:
  - A write to an empty FIFO at edge N: output register loads at edge N+1, and empty deasserts with the word on data_out after edge N+1.
  - Back-to-back pops sustain 1 word per cycle while the array is non-empty.
- Full throughput in both modes: 1 write and 1 read per cycle.

## Test plan
- ADDR_WIDTH=2, FWFT=0: write 0xA1..0xA4 on consecutive cycles -> full = 1 and level = 4 after 4th edge; a 5th write of 0xA5 -> overflow = 1, level stays 4; then 4 reads -> data_out 0xA1,0xA2,0xA3,0xA4 each with 1-cycle data_valid, then empty = 1.
- ADDR_WIDTH=2, FWFT=1: single write of 0x5C at edge N -> empty = 0 and data_out = 0x5C after edge N+1; rd_en one cycle -> empty = 1; a further rd_en -> underflow = 1.
- Wrap-around: 10 iterations of write-then-read on depth 4, data 0x00..0x09 -> every word read back in order, level never exceeds 1, no error flags.
- Thresholds with AFULL_THRESH=3, AEMPTY_THRESH=1, depth 4: fill 0->4 -> almost_empty drops at level 2, almost_full rises at level 3; simultaneous write+read at level 3 -> level stays 3, flags unchanged.
- Flush and reset: fill to 3, assert flush together with wr_en -> level = 0, empty = 1, overflow/underflow cleared, write discarded; then assert rst_n = 0 mid-burst asynchronously -> all outputs take reset values immediately, before the next clock edge.
